// File: rtl/j17_io_pkg.sv
// Shared constants and the segment decoder for the J17 I/O controller.
// Purely combinational helpers, no state.
// No flow control; values are consumed directly by the decoder and scanner.
package j17_io_pkg;

  localparam logic [9:0] ADDR_EVT  = 10'h3FD;
  localparam logic [9:0] ADDR_IN   = 10'h3FE;
  localparam logic [9:0] ADDR_DISP = 10'h3FF;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Nibble to active-low {g,f,e,d,c,b,a} glyph: 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg_v;
    case (nib)
      4'h0: seg_v = 7'b1000000;
      4'h1: seg_v = 7'b1111001;
      4'h2: seg_v = 7'b0100100;
      4'h3: seg_v = 7'b0110000;
      4'h4: seg_v = 7'b0011001;
      4'h5: seg_v = 7'b0010010;
      4'h6: seg_v = 7'b0000010;
      4'h7: seg_v = 7'b1111000;
      4'h8: seg_v = 7'b0000000;
      4'h9: seg_v = 7'b0010000;
      4'hA: seg_v = 7'b0001000;
      4'hB: seg_v = 7'b0000011;
      4'hC: seg_v = 7'b1000110;
      4'hD: seg_v = 7'b0100001;
      4'hE: seg_v = 7'b0000110;
      4'hF: seg_v = 7'b0001110;
      default: seg_v = SEG_BLANK;
    endcase
    return seg_v;
  endfunction

endpackage

// File: rtl/j17_io_ctrl_if.sv
// DP-side data-memory bus seen by the I/O controller (address, write strobe, data, hit, read data).
// read_data is valid one cycle after addr, io_hit is combinational from addr.
// No backpressure: the bus is accepted every cycle.
interface j17_io_ctrl_if;
  logic [9:0]  addr;
  logic        write;
  logic [31:0] value;
  logic        io_hit;
  logic [31:0] read_data;

  modport master (output addr, output write, output value, input io_hit, input read_data);
  modport slave  (input addr, input write, input value, output io_hit, output read_data);
endinterface

// File: rtl/j17_debouncer.sv
// Two-flop synchroniser plus debounce counter; o_db follows the input after DEBOUNCE_CYCLES stable differing cycles.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES edges from input change to o_db change.
// No backpressure; o_rise is a one-cycle pulse on the edge where o_db goes 0->1.
module j17_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_deb_cnt;
  logic          w_differ;
  logic          w_flip;

  assign w_differ = (r_sync2 != r_db);
  assign w_flip   = w_differ && (r_deb_cnt == CNT_LAST);

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive differing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_db      <= 1'b0;
      r_deb_cnt <= '0;
    end else if (!w_differ) begin
      r_deb_cnt <= '0;
    end else if (w_flip) begin
      r_db      <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign o_db   = r_db;
  // Asserted on the edge that will set r_db, so the press counter moves in step with it.
  assign o_rise = w_flip && r_sync2;

endmodule

// File: rtl/j17_io_ctrl.sv
// Memory-mapped I/O: press counter, debounced input, display register and multiplexed 7-segment scanner.
// Reads return one cycle after addr (RAM-equivalent slot); io_hit is combinational.
// No backpressure: every bus cycle is accepted; reads are read-before-write.
module j17_io_ctrl
  import j17_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REFRESH_CYCLES  = 1000,
  parameter int DIGITS          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  j17_io_ctrl_if.slave     bus,
  output logic [6:0]       seg,
  output logic [7:0]       an
);

  localparam int RCW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RCW-1:0] REF_LAST  = RCW'(REFRESH_CYCLES - 1);
  localparam logic [2:0]     SCAN_LAST = 3'(DIGITS - 1);

  logic [31:0]    r_disp;
  logic [15:0]    r_press_cnt;
  logic [31:0]    r_read_data;
  logic [RCW-1:0] r_ref_cnt;
  logic [2:0]     r_scan_idx;

  logic           w_in_db;
  logic           w_rise;
  logic           w_wr_disp;
  logic           w_clr_evt;
  logic [3:0]     w_nib;

  j17_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .i_clk (clock),
    .i_rst (reset),
    .i_raw (in),
    .o_db  (w_in_db),
    .o_rise(w_rise)
  );

  assign bus.io_hit = (bus.addr == ADDR_EVT) || (bus.addr == ADDR_IN) || (bus.addr == ADDR_DISP);
  assign w_wr_disp  = bus.write && (bus.addr == ADDR_DISP);
  assign w_clr_evt  = bus.write && (bus.addr == ADDR_EVT);

  // Display register: plain read/write location.
  always_ff @(posedge clock) begin
    if (reset) r_disp <= '0;
    else if (w_wr_disp) r_disp <= bus.value;
  end

  // Press counter: a clear write beats a simultaneous press; saturates rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset)                                 r_press_cnt <= '0;
    else if (w_clr_evt)                        r_press_cnt <= '0;
    else if (w_rise && r_press_cnt != 16'hFFFF) r_press_cnt <= r_press_cnt + 16'd1;
  end

  // Read port samples pre-write state every cycle, independent of the write strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_data <= '0;
    end else begin
      case (bus.addr)
        ADDR_EVT:  r_read_data <= {16'b0, r_press_cnt};
        ADDR_IN:   r_read_data <= {31'b0, w_in_db};
        ADDR_DISP: r_read_data <= r_disp;
        default:   r_read_data <= '0;
      endcase
    end
  end

  assign bus.read_data = r_read_data;

  // Scanner: hold each digit for REFRESH_CYCLES, then advance and wrap after the last digit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ref_cnt  <= '0;
      r_scan_idx <= '0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt  <= '0;
      r_scan_idx <= (r_scan_idx == SCAN_LAST) ? 3'd0 : r_scan_idx + 3'd1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  // Lit digit shows its nibble of the live display register, so a write shows up next cycle.
  assign w_nib = r_disp[{r_scan_idx, 2'b00} +: 4];
  assign seg   = hex7(w_nib);
  assign an    = ~(8'd1 << r_scan_idx);

endmodule

// File: tb/tb_j17_io_ctrl.sv
// Randomised and directed bench for j17_io_ctrl against a cycle-level behavioural model.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
// No backpressure on the bus; every cycle is checked.
module tb_j17_io_ctrl;

  localparam int DC  = 4;
  localparam int RC  = 2;
  localparam int DIG = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in    = 1'b0;
  logic [6:0] seg;
  logic [7:0] an;

  j17_io_ctrl_if bus_if();

  j17_io_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .REFRESH_CYCLES (RC),
    .DIGITS         (DIG)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in   (in),
    .bus  (bus_if.slave),
    .seg  (seg),
    .an   (an)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Behavioural state: sync stages, debounced level, run length of disagreement, registers, scan position.
  bit          m_s1, m_s2, m_db;
  int          m_streak, m_press, m_ref, m_idx;
  logic [31:0] m_disp, m_rd;
  int          hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_map(input logic [9:0] a);
    return a == 10'h3FD || a == 10'h3FE || a == 10'h3FF;
  endfunction

  task automatic model_edge();
    logic [31:0] rd;
    bit rise;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_streak = 0; m_press = 0;
      m_disp = '0; m_rd = '0; m_ref = 0; m_idx = 0;
      return;
    end
    case (bus_if.addr)
      10'h3FD: rd = 32'(m_press);
      10'h3FE: rd = 32'(m_db);
      10'h3FF: rd = m_disp;
      default: rd = '0;
    endcase
    rise = 0;
    if (m_s2 != m_db) begin
      m_streak++;
      if (m_streak == DC) begin
        m_db = m_s2; m_streak = 0; rise = m_db;
      end
    end else begin
      m_streak = 0;
    end
    m_s2 = m_s1;
    m_s1 = in;
    if (bus_if.write && bus_if.addr == 10'h3FF) m_disp = bus_if.value;
    if (bus_if.write && bus_if.addr == 10'h3FD) m_press = 0;
    else if (rise && m_press < 65535) m_press++;
    m_rd = rd;
    if (m_ref == RC - 1) begin
      m_ref = 0;
      m_idx = (m_idx + 1) % DIG;
    end else begin
      m_ref++;
    end
  endtask

  task automatic tick();
    logic [7:0] exp_an;
    logic [3:0] nib;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    exp_an = 8'hFF & ~(8'd1 << m_idx);
    nib    = 4'((m_disp >> (4 * m_idx)) & 32'hF);
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(glyph[nib]));
    chk("read_data", bus_if.read_data, m_rd);
    chk("io_hit", 32'(bus_if.io_hit), 32'(in_map(bus_if.addr)));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_set(input logic [9:0] a, input logic w, input logic [31:0] v);
    bus_if.addr  = a;
    bus_if.write = w;
    bus_if.value = v;
  endtask

  task automatic press_once();
    in = 1'b0; ticks(10);
    in = 1'b1; ticks(10);
  endtask

  initial begin
    int guard;
    bus_set(10'h000, 1'b0, 32'h0);
    reset = 1'b1;
    ticks(2);
    chk("rst_an", 32'(an), 32'h0000_00FE);
    chk("rst_seg", 32'(seg), 32'h0000_0040);
    chk("rst_rd", bus_if.read_data, 32'h0);
    chk("rst_hit", 32'(bus_if.io_hit), 32'h0);
    reset = 1'b0;

    // Display write, read-before-write, then read back and watch the scan.
    bus_set(10'h3FF, 1'b1, 32'h1234_ABCD);
    tick();
    chk("rbw_disp", bus_if.read_data, 32'h0);
    bus_set(10'h3FF, 1'b0, 32'h0);
    tick();
    chk("rd_disp", bus_if.read_data, 32'h1234_ABCD);
    ticks(20);

    // Short glitch is filtered; long hold registers one press.
    bus_set(10'h3FD, 1'b0, 32'h0);
    in = 1'b1; ticks(3);
    in = 1'b0; ticks(10);
    chk("glitch_cnt", bus_if.read_data, 32'h0);
    in = 1'b1; ticks(10);
    bus_set(10'h3FE, 1'b0, 32'h0); tick();
    chk("rd_in", bus_if.read_data, 32'h1);
    bus_set(10'h3FD, 1'b0, 32'h0); tick();
    chk("rd_evt1", bus_if.read_data, 32'h1);

    // Clear, three clean presses.
    bus_set(10'h3FD, 1'b1, 32'h0); tick();
    bus_set(10'h3FD, 1'b0, 32'h0);
    press_once(); press_once(); press_once();
    tick();
    chk("rd_evt3", bus_if.read_data, 32'h3);

    // Clear coinciding with the debounced rise: clear wins.
    in = 1'b0; ticks(10);
    in = 1'b1; ticks(5);
    bus_set(10'h3FD, 1'b1, 32'hFFFF_FFFF); tick();
    chk("rise_seen", 32'(m_db), 32'h1);
    bus_set(10'h3FD, 1'b0, 32'h0); tick();
    chk("clr_wins", bus_if.read_data, 32'h0);

    // Saturation from 0xFFFE.
    in = 1'b0; ticks(10);
    force dut.r_press_cnt = 16'hFFFE;
    #1 release dut.r_press_cnt;
    m_press = 16'hFFFE;
    press_once(); press_once();
    tick();
    chk("sat_cnt", bus_if.read_data, 32'h0000_FFFF);

    // Reset mid-debounce and mid-scan.
    in = 1'b0;
    bus_set(10'h3FF, 1'b1, 32'h7654_3210); tick();
    bus_set(10'h3FD, 1'b0, 32'h0);
    ticks(10);
    guard = 0;
    while (!(m_idx == 2 && m_ref == 1) && guard < 40) begin
      tick(); guard++;
    end
    chk("scan_sync_bound", 32'(guard < 40), 32'h1);
    in = 1'b1; ticks(2);
    chk("mid_an", 32'(an), 32'h0000_00F7);
    reset = 1'b1; tick();
    chk("mrst_an", 32'(an), 32'h0000_00FE);
    chk("mrst_seg", 32'(seg), 32'h0000_0040);
    chk("mrst_rd", bus_if.read_data, 32'h0);
    reset = 1'b0; in = 1'b0;
    ticks(12);
    chk("mrst_nopress", bus_if.read_data, 32'h0);

    // Random traffic against the model.
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        in   = ~in;
        hold = $urandom_range(1, 12);
      end
      hold--;
      case ($urandom_range(0, 3))
        0:       bus_if.addr = 10'h3FD;
        1:       bus_if.addr = 10'h3FE;
        2:       bus_if.addr = 10'h3FF;
        default: bus_if.addr = 10'($urandom);
      endcase
      bus_if.write = ($urandom_range(0, 3) == 0);
      bus_if.value = $urandom;
      reset        = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
